dmc_dma_unit: RTL
=================

Name: dmc_dma_unit

Overview:
- Services DMC sample fetches. Accepts a fetch request and 15-bit sample address from the DMC channel, halts the CPU through RDY, and takes ownership of the CPU bus.
- Performs one read at {1'b1, dmc_addr} and returns the byte to the DMC.
- Sits between the APU's DMC fetch port and the CPU bus/memory mux.
- Enforces 6502 halt semantics: RDY is honoured only on CPU read cycles, and the DMA read falls on a "get" cycle.

Parameters:
- ALIGN_EN, 1, 1 = insert an alignment cycle so the read falls on a cycle where apu_clk_en was low at its start tick; 0 = read immediately after the dummy cycle.

Ports:
- clk  input  1  system clock
- rst_l  input  1  asynchronous active-low reset
- cpu_clk_en  input  1  CPU cycle tick; all state transitions occur only on clk edges where this is 1
- apu_clk_en  input  1  APU half-rate tick; toggles every CPU tick, defines put/get phase
- dmc_re  input  1  fetch request from DMC, sampled on cpu_clk_en ticks
- dmc_addr  input  15  sample address, latched with the request
- dmc_read_data  output  8  fetched byte, held until the next fetch completes
- dmc_data_valid  output  1  one-clk pulse when dmc_read_data updates
- cpu_rw  input  1  1 = CPU's current cycle is a read
- cpu_rdy  output  1  0 = CPU must stall on its next read cycle
- bus_owner  output  1  1 = DMA drives the CPU bus this cycle
- bus_addr  output  16  DMA bus address
- bus_re  output  1  DMA read strobe
- bus_data_in  input  8  read data from bus, valid in READ cycle
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset values: cpu_rdy=1, bus_owner=0, bus_re=0, bus_addr=16'h0000, dmc_read_data=8'h00, dmc_data_valid=0, busy=0, state=IDLE, pending flag=0.
- All outputs are registered. State advances only on ticks (clk edge with cpu_clk_en=1).
- IDLE:
  - On a tick with dmc_re=1 (or pending flag=1), latch addr and clear pending.
  - Go to PEND; cpu_rdy<=0.
- PEND (RDY low, CPU may still be writing):
  - On a tick with cpu_rw=1, go to HALT.
  - On a tick with cpu_rw=0, stay in PEND. Write cycles are not halted; any number is tolerated.
- HALT: the CPU is stalled. Next tick goes to DUMMY.
- DUMMY, next tick:
  - If ALIGN_EN=1 and apu_clk_en=1 at this tick, go to ALIGN.
  - Otherwise go to READ.
- ALIGN: next tick goes to READ.
- On entry to READ, registered so they are valid for the whole READ cycle:
  - bus_owner=1, bus_re=1, bus_addr={1'b1, addr}.
  - bus_owner=1 is also driven in HALT, DUMMY and ALIGN, with bus_re=0 in those states.
- READ, at its ending tick:
  - dmc_read_data<=bus_data_in; dmc_data_valid<=1 for exactly one clk.
  - cpu_rdy<=1, bus_owner<=0, bus_re<=0; go to IDLE.
- Stall length counts ticks with cpu_rdy=0 after the PEND exit: 3 ticks without alignment, 4 with.
- Address: bus_addr bit 15 is forced to 1, so dmc_addr=15'h7FFF gives 16'hFFFF. No wrap logic here; the DMC wraps its own address.
- Request while busy:
  - dmc_re=1 on a tick in any non-IDLE state sets the pending flag (single-depth); further requests are merged.
  - The pending request is serviced by the IDLE→PEND transition on the tick after READ completes. Its address is the dmc_addr sampled at that tick.
- Request on the same tick READ completes: sets pending, so one extra fetch follows.
- Reset mid-operation: async return to reset values. The CPU is released immediately and any in-flight byte is discarded.
- dmc_data_valid never asserts without a preceding READ state.

Test Plan:
- DMC request with addr 15'h4000 during continuous CPU reads, apu_clk_en=0 at the DUMMY tick -> bus_addr=16'hC000 and bus_re=1 for one CPU cycle; cpu_rdy low exactly 3 ticks; bus_data_in=8'hA5 gives dmc_read_data=8'hA5 with a one-clk valid pulse.
- Same stimulus with apu_clk_en=1 at the DUMMY tick -> ALIGN inserted, cpu_rdy low 4 ticks, read byte correct. With ALIGN_EN=0 -> 3 ticks.
- Request while CPU issues 2 write cycles then a read -> PEND held for 2 ticks with bus_owner=0, HALT entered on the read tick, total cpu_rdy low = 2 + 3/4 ticks.
- Second dmc_re (addr 15'h7FFF) pulsed during DUMMY of the first fetch -> first completes; second starts the next tick with bus_addr=16'hFFFF; two valid pulses, in order.
- rst_l asserted during READ -> cpu_rdy=1, bus_owner=0, bus_re=0, busy=0 immediately; no valid pulse; dmc_read_data=8'h00.

Source files
------------

// File: rtl/dmc_dma_unit_if.sv
// -----------------------------------------------------------------------------
// dmc_dma_unit_if
//
// Bundles the DMC fetch port, the CPU halt handshake and the CPU bus signals
// used by the DMC sample-fetch DMA engine.
//
// Signals
//   cpu_clk_en      CPU cycle tick; the DMA only changes state on these clocks
//   apu_clk_en      APU half-rate tick, toggles every CPU tick (put/get phase)
//   dmc_re          fetch request from the DMC channel
//   dmc_addr[14:0]  sample address accompanying the request
//   dmc_read_data   fetched byte, held until the next fetch completes
//   dmc_data_valid  one-clock pulse when dmc_read_data updates
//   cpu_rw          1 = the CPU's current cycle is a read
//   cpu_rdy         0 = CPU must stall on its next read cycle
//   bus_owner       1 = DMA owns the CPU bus this cycle
//   bus_addr[15:0]  DMA bus address
//   bus_re          DMA read strobe
//   bus_data_in     read data returned by the bus during the DMA read cycle
//   busy            1 whenever the DMA is not idle
//
// Modports
//   master  the DMA engine (drives the bus and the CPU halt line)
//   slave   the surrounding system: DMC, CPU core and memory mux
// -----------------------------------------------------------------------------
interface dmc_dma_unit_if;
    logic        cpu_clk_en;
    logic        apu_clk_en;
    logic        dmc_re;
    logic [14:0] dmc_addr;
    logic [7:0]  dmc_read_data;
    logic        dmc_data_valid;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic        bus_owner;
    logic [15:0] bus_addr;
    logic        bus_re;
    logic [7:0]  bus_data_in;
    logic        busy;

    modport master (
        input  cpu_clk_en,
        input  apu_clk_en,
        input  dmc_re,
        input  dmc_addr,
        input  cpu_rw,
        input  bus_data_in,
        output dmc_read_data,
        output dmc_data_valid,
        output cpu_rdy,
        output bus_owner,
        output bus_addr,
        output bus_re,
        output busy
    );

    modport slave (
        output cpu_clk_en,
        output apu_clk_en,
        output dmc_re,
        output dmc_addr,
        output cpu_rw,
        output bus_data_in,
        input  dmc_read_data,
        input  dmc_data_valid,
        input  cpu_rdy,
        input  bus_owner,
        input  bus_addr,
        input  bus_re,
        input  busy
    );
endinterface

// File: rtl/dmc_dma_unit.sv
// -----------------------------------------------------------------------------
// dmc_dma_unit
//
// DMC sample-fetch DMA engine. A fetch request from the DMC pulls RDY low,
// waits for the CPU to reach a read cycle (writes are never halted), spends a
// halt and a dummy cycle, optionally one alignment cycle so the read lands on
// a "get" cycle, then reads {1'b1, dmc_addr} from the CPU bus and hands the
// byte back to the DMC with a one-clock valid pulse.
//
// Parameters
//   ALIGN_EN  1 = insert an alignment cycle when apu_clk_en is high at the
//                 tick leaving the dummy cycle; 0 = read right after dummy
//
// Ports
//   clk     system clock
//   rst_l   asynchronous active-low reset
//   dma     dmc_dma_unit_if.master bundle (DMC port, CPU handshake, bus)
//
// All outputs are registered. State only moves on clocks with cpu_clk_en=1.
// -----------------------------------------------------------------------------
module dmc_dma_unit #(
    parameter bit ALIGN_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_l,
    dmc_dma_unit_if.master dma
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PEND  = 3'd1,
        ST_HALT  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_ALIGN = 3'd4,
        ST_READ  = 3'd5
    } state_t;

    state_t      state_q,     state_d;
    logic        pending_q,   pending_d;
    logic [14:0] addr_q,      addr_d;
    logic [7:0]  rd_data_q,   rd_data_d;
    logic        valid_q,     valid_d;
    logic        cpu_rdy_q,   cpu_rdy_d;
    logic        bus_owner_q, bus_owner_d;
    logic        bus_re_q,    bus_re_d;
    logic [15:0] bus_addr_q,  bus_addr_d;
    logic        busy_q,      busy_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        valid_d   = 1'b0;

        if (dma.cpu_clk_en) begin
            // A request arriving while a fetch is in flight is remembered in a
            // single flag; repeated requests merge into it.
            if ((state_q != ST_IDLE) && dma.dmc_re) begin
                pending_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // The address is taken from the DMC at the start tick,
                    // also for a request that was held in the pending flag.
                    if (dma.dmc_re || pending_q) begin
                        addr_d    = dma.dmc_addr;
                        pending_d = 1'b0;
                        state_d   = ST_PEND;
                    end
                end
                ST_PEND: begin
                    // RDY only stalls the 6502 on a read cycle.
                    if (dma.cpu_rw) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_DUMMY;
                end
                ST_DUMMY: begin
                    // apu_clk_en high here would put the read on a put cycle;
                    // burn one more cycle to move it onto a get cycle.
                    if (ALIGN_EN && dma.apu_clk_en) begin
                        state_d = ST_ALIGN;
                    end else begin
                        state_d = ST_READ;
                    end
                end
                ST_ALIGN: begin
                    state_d = ST_READ;
                end
                ST_READ: begin
                    rd_data_d = dma.bus_data_in;
                    valid_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs, derived from the state being entered so that they
    // are valid for the whole cycle spent in that state.
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_rdy_d   = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        bus_owner_d = (state_d == ST_HALT)  || (state_d == ST_DUMMY) ||
                      (state_d == ST_ALIGN) || (state_d == ST_READ);
        bus_re_d    = (state_d == ST_READ);
        bus_addr_d  = bus_addr_q;
        if ((state_d == ST_READ) && (state_q != ST_READ)) begin
            bus_addr_d = {1'b1, addr_q};
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            addr_q      <= 15'h0000;
            rd_data_q   <= 8'h00;
            valid_q     <= 1'b0;
            cpu_rdy_q   <= 1'b1;
            bus_owner_q <= 1'b0;
            bus_re_q    <= 1'b0;
            bus_addr_q  <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
            valid_q     <= valid_d;
            cpu_rdy_q   <= cpu_rdy_d;
            bus_owner_q <= bus_owner_d;
            bus_re_q    <= bus_re_d;
            bus_addr_q  <= bus_addr_d;
            busy_q      <= busy_d;
        end
    end

    assign dma.dmc_read_data  = rd_data_q;
    assign dma.dmc_data_valid = valid_q;
    assign dma.cpu_rdy        = cpu_rdy_q;
    assign dma.bus_owner      = bus_owner_q;
    assign dma.bus_re         = bus_re_q;
    assign dma.bus_addr       = bus_addr_q;
    assign dma.busy           = busy_q;

endmodule
